// File: rtl/pipeline_ctrl.sv
// Hazard controller for a five-stage pipeline: load-use stalls, branch flushes
// and a multi-cycle mult/div hold FSM with a saturating stall counter.
module pipeline_ctrl #(
    parameter int MD_LATENCY = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_insn,
    input  logic [31:0] dx_insn,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_en,
    output logic        fd_en,
    output logic        dx_en,
    output logic        xm_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_bubble,
    output logic        md_busy,
    output logic [15:0] stall_cycles
);

    localparam int CW = $clog2(MD_LATENCY) + 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;

    logic [4:0] fd_op, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_aluop;
    logic       dx_load, dx_md, fd_reads_rs, fd_reads_rt, load_use, md_exit;
    logic       unused_insn_bits;

    assign fd_op    = fd_insn[31:27];
    assign fd_rs    = fd_insn[21:17];
    assign fd_rt    = fd_insn[16:12];
    assign dx_op    = dx_insn[31:27];
    assign dx_rd    = dx_insn[26:22];
    assign dx_aluop = dx_insn[6:2];
    assign unused_insn_bits = ^{fd_insn[26:22], fd_insn[11:0], dx_insn[21:7], dx_insn[1:0]};

    assign dx_load     = (dx_op == 5'b01000);
    assign dx_md       = (dx_op == 5'b00000) && ((dx_aluop == 5'b00110) || (dx_aluop == 5'b00111));
    assign fd_reads_rt = (fd_op == 5'b00000);
    assign fd_reads_rs = !((fd_op == 5'b00001) || (fd_op == 5'b00011) || (fd_op == 5'b10101));
    assign load_use    = dx_load && (dx_rd != 5'd0) &&
                         ((fd_reads_rs && (dx_rd == fd_rs)) || (fd_reads_rt && (dx_rd == fd_rt)));

    // The triggering IDLE cycle already stalls, so BUSY ends as the countdown reaches zero.
    assign md_exit = md_ready || (count <= CW'(1));

    always_comb begin
        state_next = state;
        count_next = count;
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        dx_en      = 1'b1;
        xm_en      = 1'b1;
        mw_en      = 1'b1;
        fd_flush   = 1'b0;
        dx_flush   = 1'b0;
        xm_bubble  = 1'b0;
        case (state)
            IDLE: begin
                if (dx_md) begin
                    state_next = BUSY;
                    count_next = COUNT_LOAD;
                    pc_en      = 1'b0;
                    fd_en      = 1'b0;
                    dx_en      = 1'b0;
                    xm_bubble  = 1'b1;
                end else if (branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            BUSY: begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_bubble = 1'b1;
                if (count != '0) begin
                    count_next = count - CW'(1);
                end
                if (md_exit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            stall_cycles <= 16'h0000;
        end else begin
            state <= state_next;
            count <= count_next;
            if (!pc_en && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'h0001;
            end
        end
    end

    assign md_busy = (state == BUSY);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: expected control vectors are queued as
// stimulus is applied and popped when outputs are sampled on the falling edge.
module tb_pipeline_ctrl;

    logic        clock;
    logic        reset;
    logic [31:0] fd_insn;
    logic [31:0] dx_insn;
    logic        branch_taken;
    logic        md_ready;
    logic        pc_en, fd_en, dx_en, xm_en, mw_en;
    logic        fd_flush, dx_flush, xm_bubble, md_busy;
    logic [15:0] stall_cycles;
    logic [8:0]  ctl;

    int errors = 0;
    int checks = 0;

    // Packed as {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble, md_busy}
    localparam logic [8:0] NORMAL  = 9'b11111_000_0;
    localparam logic [8:0] LU      = 9'b00111_010_0;
    localparam logic [8:0] BR      = 9'b11111_110_0;
    localparam logic [8:0] MD_TRIG = 9'b00011_001_0;
    localparam logic [8:0] MD_BUSY = 9'b00011_001_1;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
    } exp_t;

    exp_t sb[$];

    pipeline_ctrl #(.MD_LATENCY(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_insn      (fd_insn),
        .dx_insn      (dx_insn),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .xm_en        (xm_en),
        .mw_en        (mw_en),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_bubble    (xm_bubble),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    assign ctl = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble, md_busy};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
        return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                                 input logic rdy, input logic [8:0] exp_ctl, input string tag);
        exp_t e;
        fd_insn      = fd;
        dx_insn      = dx;
        branch_taken = br;
        md_ready     = rdy;
        e.tag = tag;
        e.ctl = exp_ctl;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: got no entry, required one");
        end else begin
            e = sb.pop_front();
            assert (ctl === e.ctl) else begin
                errors++;
                $error("[TB] FAIL %s: got %b required %b", e.tag, ctl, e.ctl);
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp_val);
        checks++;
        assert (got === exp_val) else begin
            errors++;
            $error("[TB] FAIL %s: got %0d required %0d", tag, got, exp_val);
        end
    endtask

    task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                        input logic rdy, input logic [8:0] exp_ctl, input string tag);
        applyStimulus(fd, dx, br, rdy, exp_ctl, tag);
        @(negedge clock);
        checkOutput();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        fd_insn      = 32'h0;
        dx_insn      = 32'h0;
        branch_taken = 1'b0;
        md_ready     = 1'b0;

        #2;
        checkValue("reset_ctl", {7'd0, ctl}, {7'd0, NORMAL});
        checkValue("reset_stalls", stall_cycles, 16'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        step(enc(5'd0, 5'd3, 5'd1, 5'd2, 5'd0), enc(5'd0, 5'd4, 5'd6, 5'd7, 5'd0), 1'b0, 1'b0, NORMAL, "no_hazard");

        // Load-use on rs, then recovery with a nop in D/X
        step(enc(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), enc(5'd8, 5'd5, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, LU, "lu_rs");
        step(enc(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), 32'h0, 1'b0, 1'b0, NORMAL, "lu_rs_recover");
        checkValue("stalls_after_lu", stall_cycles, 16'd1);

        step(enc(5'd0, 5'd6, 5'd1, 5'd7, 5'd0), enc(5'd8, 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, LU, "lu_rt");
        checkValue("stalls_after_lu_rt", stall_cycles, 16'd2);
        step(enc(5'd1, 5'd0, 5'd7, 5'd0, 5'd0), enc(5'd8, 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, NORMAL, "no_rs_op1");
        step(enc(5'd5, 5'd9, 5'd1, 5'd7, 5'd0), enc(5'd8, 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, NORMAL, "itype_no_rt");
        step(enc(5'd21, 5'd0, 5'd7, 5'd7, 5'd0), enc(5'd8, 5'd7, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, NORMAL, "no_rs_op21");
        step(enc(5'd0, 5'd1, 5'd0, 5'd0, 5'd0), enc(5'd8, 5'd0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, NORMAL, "lw_r0");
        checkValue("stalls_r0", stall_cycles, 16'd2);

        step(enc(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), enc(5'd8, 5'd5, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, BR, "branch_over_lu");
        checkValue("stalls_branch", stall_cycles, 16'd2);

        // Multiply with no early ready: full latency, branch in BUSY ignored
        step(enc(5'd0, 5'd11, 5'd10, 5'd3, 5'd0), enc(5'd0, 5'd10, 5'd1, 5'd2, 5'd6), 1'b0, 1'b0, MD_TRIG, "mul_trigger");
        for (int i = 0; i < 31; i++) begin
            step(enc(5'd0, 5'd11, 5'd10, 5'd3, 5'd0), enc(5'd0, 5'd10, 5'd1, 5'd2, 5'd6),
                 (i == 5), 1'b0, MD_BUSY, $sformatf("mul_busy_%0d", i));
        end
        step(enc(5'd0, 5'd11, 5'd10, 5'd3, 5'd0), enc(5'd0, 5'd10, 5'd1, 5'd2, 5'd6), 1'b0, 1'b0, NORMAL, "mul_done");
        step(enc(5'd0, 5'd11, 5'd10, 5'd3, 5'd0), 32'h0, 1'b0, 1'b0, NORMAL, "mul_idle");
        checkValue("stalls_mul", stall_cycles, 16'd34);

        // Divide released early by md_ready on the third BUSY cycle
        step(32'h0, enc(5'd0, 5'd12, 5'd1, 5'd2, 5'd7), 1'b0, 1'b0, MD_TRIG, "div_trigger");
        for (int i = 0; i < 3; i++) begin
            step(32'h0, enc(5'd0, 5'd12, 5'd1, 5'd2, 5'd7), 1'b0, (i == 2), MD_BUSY, $sformatf("div_busy_%0d", i));
        end
        step(32'h0, enc(5'd0, 5'd12, 5'd1, 5'd2, 5'd7), 1'b0, 1'b0, NORMAL, "div_done");
        step(32'h0, 32'h0, 1'b0, 1'b0, NORMAL, "div_idle");
        checkValue("stalls_div", stall_cycles, 16'd38);

        // Asynchronous reset between edges while BUSY
        step(32'h0, enc(5'd0, 5'd13, 5'd1, 5'd2, 5'd6), 1'b0, 1'b0, MD_TRIG, "rst_mul_trigger");
        step(32'h0, enc(5'd0, 5'd13, 5'd1, 5'd2, 5'd6), 1'b0, 1'b0, MD_BUSY, "rst_mul_busy_0");
        step(32'h0, enc(5'd0, 5'd13, 5'd1, 5'd2, 5'd6), 1'b0, 1'b0, MD_BUSY, "rst_mul_busy_1");
        #1;
        reset = 1'b0;
        #1;
        checkValue("async_md_busy", {15'd0, md_busy}, 16'd0);
        checkValue("async_stalls", stall_cycles, 16'd0);
        dx_insn = 32'h0;
        #1;
        reset = 1'b1;
        step(32'h0, 32'h0, 1'b0, 1'b0, NORMAL, "after_reset_0");
        step(32'h0, 32'h0, 1'b0, 1'b0, NORMAL, "after_reset_1");
        checkValue("stalls_after_reset", stall_cycles, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 32: maximum mult/div busy cycles before forced release.
REQ-002 SHALL have port clock  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port fd_insn  in  32: instruction held in the F/D latch.
REQ-005 SHALL have port dx_insn  in  32: instruction held in the D/X latch.
REQ-006 SHALL have port branch_taken  in  1: X-stage branch/jump redirect this cycle.
REQ-007 SHALL have port md_ready  in  1: mult/div unit result valid.
REQ-008 SHALL have ports pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each: latch enables.
REQ-009 SHALL have ports fd_flush, dx_flush, xm_bubble  out  1 each: force a nop (32'h0) into F/D, D/X, X/M respectively.
REQ-010 SHALL have port md_busy  out  1: FSM in BUSY.
REQ-011 SHALL have port stall_cycles  out  16: saturating count of cycles with pc_en low.

Function
REQ-012 SHALL decode fields as opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
REQ-013 SHALL treat dx_insn as load when opcode=01000, as mult/div when opcode=00000 and aluop in {00110, 00111}.
REQ-014 SHALL treat fd_insn as reading rt only for opcode 00000 (R-type); rs is read for all opcodes except 00001, 00011, 10101.
REQ-015 SHALL flag load-use when dx is load, dx rd != 0, and dx rd equals an fd source register that fd reads.
REQ-016 SHALL implement a 3-state FSM: IDLE, BUSY, DONE.
REQ-017 IDLE -> BUSY when dx is mult/div; countdown loads MD_LATENCY-1.
REQ-018 BUSY: countdown decrements each cycle; -> DONE when md_ready=1 or countdown=0, whichever comes first.
REQ-019 DONE -> IDLE unconditionally after one cycle; DONE SHALL NOT re-trigger on the same dx_insn.
REQ-020 In BUSY, and in the IDLE cycle that triggers BUSY: pc_en=fd_en=dx_en=0, xm_en=mw_en=1, xm_bubble=1.
REQ-021 In DONE: all enables 1, no bubble; the mult/div instruction advances into X/M.
REQ-022 Load-use (FSM IDLE, no mult/div in dx): pc_en=fd_en=0, dx_flush=1, others enabled; lasts exactly one cycle.
REQ-023 branch_taken=1: fd_flush=1 and dx_flush=1 and all enables 1; takes priority over load-use.
REQ-024 branch_taken while FSM not IDLE SHALL be ignored (X holds the mult/div).
REQ-025 No hazard: all enables 1, all flush/bubble 0.
REQ-026 Enables and flushes SHALL be combinational from inputs and FSM state; FSM, countdown and stall_cycles are registered.
REQ-027 stall_cycles SHALL increment on each cycle pc_en=0 and hold at 16'hFFFF.
REQ-028 Countdown width SHALL be ceil(log2(MD_LATENCY))+1 bits; MD_LATENCY=1 SHALL yield one BUSY cycle.

Reset
REQ-029 reset=0 SHALL immediately force FSM IDLE, countdown 0, stall_cycles 0, md_busy 0, independent of clock.
REQ-030 With all-zero instructions after reset, outputs SHALL be: all enables 1, all flush/bubble 0.
REQ-031 Reset asserted in BUSY SHALL abort the operation; no DONE cycle follows.

Verification
REQ-032 dx=lw rd=5, fd=add rs=5 -> one cycle pc_en=0, fd_en=0, dx_flush=1; next cycle (dx=nop) all enables 1; stall_cycles=1.
REQ-033 dx=lw rd=0, fd rs=0 -> no stall, stall_cycles unchanged.
REQ-034 dx=mul, MD_LATENCY=32, md_ready low -> pc_en low 32 cycles, then DONE one cycle with all enables 1, then IDLE; stall_cycles=32.
REQ-035 dx=div, md_ready=1 on third BUSY cycle -> DONE next cycle; total pc_en-low cycles = 4.
REQ-036 branch_taken=1 coincident with load-use -> fd_flush=1, dx_flush=1, pc_en=1, no stall.
REQ-037 reset driven low mid-BUSY between clock edges -> md_busy=0 and stall_cycles=0 before next edge; all enables 1 after release.
